sample_frame_demux: RTL

//   Parametrised successor of the single-stream FT245->FIFO->modulator path: parses framed bytes

---
 rtl/sample_frame_demux.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sample_frame_demux.sv
`default_nettype none
// ============================================================================
// Module   : sample_frame_demux
// Purpose  : Parses SYNC/HDR/LEN/payload frames from the FT245 byte stream and
//            steers payload to one of NUM_CH channel streams or writes a
//            per-channel mode register. Optional trailing XOR checksum is
//            enabled by defining SAMPLE_FRAME_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sample_frame_demux #(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          ERR_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_ch_data,
  output logic [NUM_CH-1:0]      o_ch_valid,
  input  logic [NUM_CH-1:0]      i_ch_ready,
  output logic [NUM_CH*8-1:0]    o_mode,
  output logic                   o_frame_done,
  output logic                   o_err_pulse,
  output logic [ERR_W-1:0]       o_err_cnt
);

  localparam logic [7:0] c_NUM_CH = 8'(NUM_CH);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_cfg;
  logic [6:0]          r_ch_id;
  logic [7:0]          r_cnt;
  logic [NUM_CH*8-1:0] r_mode;
  logic                r_frame_done;
  logic                r_err_pulse;
  logic [ERR_W-1:0]    r_err_cnt;
`ifdef SAMPLE_FRAME_CSUM_EN
  logic [7:0]          r_csum;
  logic [7:0]          r_last;
`endif

  logic [NUM_CH-1:0]   w_ch_hit;
  logic                w_ch_ok;
  logic                w_fwd;
  logic                w_xfer;
  logic                w_hdr_ok;
  logic                w_err_evt;
  logic                w_done_evt;
  logic                w_mode_we;
  logic [7:0]          w_mode_val;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_hit
    assign w_ch_hit[k] = (r_ch_id == 7'(k));
  end

  // Out-of-range ids match no bit, so the frame is consumed with ready held high.
  assign w_ch_ok  = |w_ch_hit;
  assign w_fwd    = (r_state == S_DATA) && !r_cfg && w_ch_ok;
  assign w_hdr_ok = ({1'b0, i_data[6:0]} < c_NUM_CH);

  assign o_ready    = rst_n && (!w_fwd || |(w_ch_hit & i_ch_ready));
  assign w_xfer     = i_valid && o_ready;
  assign o_ch_valid = (w_fwd && i_valid) ? w_ch_hit : '0;
  assign o_ch_data  = (r_state == S_DATA) ? i_data : '0;

  assign o_mode       = r_mode;
  assign o_frame_done = r_frame_done;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_cnt    = r_err_cnt;

  always_comb begin
    w_err_evt  = 1'b0;
    w_done_evt = 1'b0;
    w_mode_we  = 1'b0;
    w_mode_val = i_data[7:0];
    if (w_xfer) begin
      case (r_state)
        S_HDR:  w_err_evt = !w_hdr_ok;
`ifdef SAMPLE_FRAME_CSUM_EN
        S_CSUM: begin
          if (i_data[7:0] == r_csum) begin
            w_done_evt = w_ch_ok;
            w_mode_we  = w_ch_ok && r_cfg;
            w_mode_val = r_last;
          end else begin
            w_err_evt  = 1'b1;
          end
        end
`else
        S_DATA: begin
          if (r_cnt == 8'd0) begin
            w_done_evt = w_ch_ok;
            w_mode_we  = w_ch_ok && r_cfg;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_HUNT;
      r_cfg        <= 1'b0;
      r_ch_id      <= 7'd0;
      r_cnt        <= 8'd0;
      r_mode       <= '0;
      r_frame_done <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
`ifdef SAMPLE_FRAME_CSUM_EN
      r_csum       <= 8'd0;
      r_last       <= 8'd0;
`endif
    end else begin
      r_frame_done <= w_done_evt;
      r_err_pulse  <= w_err_evt;
      if (w_err_evt && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_mode_we && w_ch_hit[k]) begin
          r_mode[k*8 +: 8] <= w_mode_val;
        end
      end
      if (w_xfer) begin
        case (r_state)
          S_HUNT: begin
            if (i_data[7:0] == SYNC_BYTE) r_state <= S_HDR;
          end
          S_HDR: begin
            r_cfg   <= i_data[7];
            r_ch_id <= i_data[6:0];
`ifdef SAMPLE_FRAME_CSUM_EN
            r_csum  <= i_data[7:0];
`endif
            r_state <= S_LEN;
          end
          S_LEN: begin
            r_cnt   <= i_data[7:0];
`ifdef SAMPLE_FRAME_CSUM_EN
            r_csum  <= r_csum ^ i_data[7:0];
`endif
            r_state <= S_DATA;
          end
          S_DATA: begin
`ifdef SAMPLE_FRAME_CSUM_EN
            r_csum <= r_csum ^ i_data[7:0];
            r_last <= i_data[7:0];
`endif
            // LEN counts payload bytes minus one, so 8'hFF yields 256 bytes.
            if (r_cnt == 8'd0) begin
`ifdef SAMPLE_FRAME_CSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_HUNT;
`endif
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
`ifdef SAMPLE_FRAME_CSUM_EN
          S_CSUM:  r_state <= S_HUNT;
`endif
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
